lzc_seq_ctrl: RTL and testbench

LZC_SEQ_CTRL -- requirements
Module: lzc_seq_ctrl

---
 rtl/lzc_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_lzc_seq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lzc_seq_ctrl.sv
// Sequential leading-zero counter and normaliser: scans the operand CHUNK_W bits
// per cycle from the MSB, then holds count, zero flag and normalised value until consumed.
module lzc_seq_ctrl #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DATA_W)-1:0] out_zcnt,
    output logic                      out_zero,
    output logic [DATA_W-1:0]         out_norm
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam int LZ_W   = $clog2(CHUNK_W);
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [CNT_W-1:0]    zcnt_q, zcnt_d;
    logic                zero_q, zero_d;
    logic [DATA_W-1:0]   norm_q, norm_d;

    logic [CHUNK_W-1:0]  chunk_s;
    logic [LZ_W-1:0]     chunk_lz_s;
    logic [CNT_W-1:0]    k_base_s;

    // Leading zeros of one chunk; only meaningful when the chunk is nonzero.
    function automatic logic [LZ_W-1:0] chunk_lz(input logic [CHUNK_W-1:0] c);
        logic [LZ_W-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (!found && c[i]) begin
                r     = LZ_W'(CHUNK_W - 1 - i);
                found = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Chunk under examination and the bit offset of chunks already skipped.
    always_comb begin
        chunk_s    = work_q[DATA_W-1 -: CHUNK_W];
        chunk_lz_s = chunk_lz(chunk_s);
        k_base_s   = CNT_W'(k_q) << LZ_W;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        k_d     = k_q;
        zcnt_d  = zcnt_q;
        zero_d  = zero_q;
        norm_d  = norm_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    k_d     = '0;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (chunk_s != '0) begin
                    zcnt_d  = k_base_s + CNT_W'(chunk_lz_s);
                    norm_d  = work_q << chunk_lz_s;
                    zero_d  = 1'b0;
                    state_d = DONE;
                end else if (k_q == K_LAST) begin
                    zcnt_d  = '0;
                    norm_d  = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    work_d  = work_q << CHUNK_W;
                    k_d     = k_q + 1'b1;
                    state_d = SCAN;
                end
            end
            DONE: begin
                // Going straight to IDLE keeps a new accept out of the handshake cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            k_q     <= '0;
            zcnt_q  <= '0;
            zero_q  <= 1'b0;
            norm_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            k_q     <= k_d;
            zcnt_q  <= zcnt_d;
            zero_q  <= zero_d;
            norm_q  <= norm_d;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_zcnt  = zcnt_q;
        out_zero  = zero_q;
        out_norm  = norm_q;
    end

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// Self-checking bench for lzc_seq_ctrl (DATA_W=64, CHUNK_W=16): directed cases,
// reset behaviour and randomised operands against a bit-scan reference model.
module tb_lzc_seq_ctrl;

    localparam int DW   = 64;
    localparam int CW   = 16;
    localparam int NC   = DW / CW;
    localparam int CNTW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CNTW-1:0] out_zcnt;
    logic            out_zero;
    logic [DW-1:0]   out_norm;

    int passes = 0;
    int checks = 0;

    lzc_seq_ctrl #(.DATA_W(DW), .CHUNK_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_zcnt  (out_zcnt),
        .out_zero  (out_zero),
        .out_norm  (out_norm)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] junk();
        return {$urandom, $urandom};
    endfunction

    // Reference: position of the highest set bit gives the count; shift by it.
    function automatic void ref_model(input logic [63:0] d, output int zc, output logic zr,
                                      output logic [63:0] nm, output int lat);
        int msb;
        msb = -1;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) msb = i;
        end
        zr = (msb < 0);
        if (zr) begin
            zc  = 0;
            nm  = 64'd0;
            lat = NC + 1;
        end else begin
            zc  = DW - 1 - msb;
            nm  = d << zc;
            lat = zc / CW + 2;
        end
    endfunction

    // One operation: accept, wait for result, optional backpressure, handshake.
    task automatic run_op(input logic [63:0] d, input int hold, input bit b2b);
        int         zc, lat, n;
        logic       zr;
        logic [63:0] nm;
        ref_model(d, zc, zr, nm, lat);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        n = 1;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = junk();
            step();
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("zcnt", 64'(out_zcnt), 64'(zc));
        chk("zero", 64'(out_zero), 64'(zr));
        chk("norm", out_norm, nm);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = junk();
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_zcnt", 64'(out_zcnt), 64'(zc));
            chk("hold_norm", out_norm, nm);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = junk();
        step();
        chk("done_one_cycle", 64'(out_valid), 64'd0);
        chk("ready_after_handshake", 64'(in_ready), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!b2b) begin
            step();
            chk("no_capture_at_handshake", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int          pulses;
        logic [63:0] d;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hFFFF_0000_0000_0000;
        out_ready = 1'b0;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_zcnt", 64'(out_zcnt), 64'd0);
        chk("rst_zero", 64'(out_zero), 64'd0);
        chk("rst_norm", out_norm, 64'd0);
        step();
        chk("no_accept_during_rst", 64'(in_ready), 64'd1);

        run_op(64'h8000_0000_0000_0000, 0, 1'b0);
        run_op(64'h0000_0000_0001_0000, 3, 1'b0);
        run_op(64'h0000_0000_0000_0000, 0, 1'b0);
        run_op(64'h0000_0000_0000_0001, 1, 1'b0);

        // Reset in cycle 2 of an all-zero scan discards the operation.
        in_valid = 1'b1;
        in_data  = 64'd0;
        step();
        in_valid = 1'b0;
        step();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h0000_1234_0000_0000;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midscan_rst_in_ready", 64'(in_ready), 64'd1);
        chk("midscan_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midscan_rst_zcnt", 64'(out_zcnt), 64'd0);
        chk("midscan_rst_zero", 64'(out_zero), 64'd0);
        chk("midscan_rst_norm", out_norm, 64'd0);
        pulses    = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid || !in_ready) pulses++;
        end
        out_ready = 1'b0;
        chk("no_discarded_result", 64'(pulses), 64'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) d = 64'd0;
            else d = junk() >> $urandom_range(0, 63);
            run_op(d, ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
